jtframe_upld: RTL and testbench

Upload adapter, the read-back counterpart of the ROM download path. Serves byte read requests from the ioctl interface (e.g. NVRAM or high-score save to the HPS) by issuing 16-bit word reads to the SDRAM controller, and returns the addressed byte. A one-word cache lets the odd byte of a word be served without a second SDRAM access. Sits between the ioctl upload port and the SDRAM programming/read port.

---
 rtl/jtframe_upld.sv | 109 ++++++++++
 tb/tb_jtframe_upld.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jtframe_upld.sv
// Upload adapter: serves ioctl byte reads from SDRAM 16-bit words, with a
// one-word cache so the second byte of a word needs no extra SDRAM access.
module jtframe_upld #(
  parameter logic [21:0] SDRAM_OFFSET = 22'd0,
  parameter logic [7:0]  TIMEOUT      = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uploading,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        upld_err,
  output logic [21:0] prog_addr,
  output logic        prog_rd,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] data_read
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [7:0]  timer;
  logic        odd;
  logic        cache_valid;
  logic [21:0] cache_tag;
  logic [15:0] cache_word;

  logic [21:0] word_addr;
  logic        cache_hit;
  logic        timer_done;

  // Sum is 22 bits wide, so the offset wraps modulo 2^22.
  assign word_addr  = ioctl_addr[22:1] + SDRAM_OFFSET;
  assign cache_hit  = cache_valid && (cache_tag == word_addr);
  assign timer_done = (8'(timer + 8'd1) == TIMEOUT);

  // Even byte addresses live in the upper half, matching the download masks.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic lane);
    return lane ? word[7:0] : word[15:8];
  endfunction

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= 8'd0;
      odd         <= 1'b0;
      cache_valid <= 1'b0;
      prog_addr   <= 22'd0;
      prog_rd     <= 1'b0;
      ioctl_din   <= 8'd0;
      ioctl_wait  <= 1'b0;
      upld_err    <= 1'b0;
    end else if (!uploading) begin
      state       <= IDLE;
      timer       <= 8'd0;
      cache_valid <= 1'b0;
      prog_rd     <= 1'b0;
      ioctl_wait  <= 1'b0;
      upld_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_rd) begin
            if (cache_hit) begin
              ioctl_din <= pick_byte(cache_word, ioctl_addr[0]);
            end else begin
              prog_addr  <= word_addr;
              prog_rd    <= 1'b1;
              ioctl_wait <= 1'b1;
              odd        <= ioctl_addr[0];
              timer      <= 8'd0;
              state      <= REQ;
            end
          end
        end
        REQ, WAIT: begin
          timer <= timer + 8'd1;
          // Completion wins over a timeout landing on the same cycle.
          if (data_rdy && (state == WAIT || sdram_ack)) begin
            cache_tag   <= prog_addr;
            cache_word  <= data_read;
            cache_valid <= 1'b1;
            ioctl_din   <= pick_byte(data_read, odd);
            ioctl_wait  <= 1'b0;
            prog_rd     <= 1'b0;
            state       <= IDLE;
          end else if (timer_done) begin
            ioctl_din   <= 8'hFF;
            ioctl_wait  <= 1'b0;
            prog_rd     <= 1'b0;
            cache_valid <= 1'b0;
            upld_err    <= 1'b1;
            state       <= IDLE;
          end else if (state == REQ && sdram_ack) begin
            prog_rd <= 1'b0;
            state   <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_upld.sv
// Directed bench for jtframe_upld: two instances share stimulus, one with a
// wrapping SDRAM offset; both use a short timeout.
module tb_jtframe_upld;

  logic        clk = 1'b0;
  logic        rst;
  logic        uploading;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] data_read;

  logic [7:0]  din0, din1;
  logic        wait0, wait1, err0, err1, prd0, prd1;
  logic [21:0] paddr0, paddr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_upld #(.SDRAM_OFFSET(22'd0), .TIMEOUT(8'd8)) dut0 (
    .clk(clk), .rst(rst), .uploading(uploading), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_din(din0), .ioctl_wait(wait0), .upld_err(err0),
    .prog_addr(paddr0), .prog_rd(prd0), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  jtframe_upld #(.SDRAM_OFFSET(22'h3FFFFF), .TIMEOUT(8'd8)) dut1 (
    .clk(clk), .rst(rst), .uploading(uploading), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_din(din1), .ioctl_wait(wait1), .upld_err(err1),
    .prog_addr(paddr1), .prog_rd(prd1), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; uploading = 1'b0; ioctl_addr = '0; ioctl_rd = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    step(); step();
    checks++; if (din0 !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", din0); end
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", wait0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err0); end
    checks++; if (prd0 !== 1'b0) begin errors++; $display("FAIL reset_prog_rd got %b want 0", prd0); end
    checks++; if (paddr0 !== 22'd0) begin errors++; $display("FAIL reset_prog_addr got %h want 0", paddr0); end
    rst = 1'b0; uploading = 1'b1;
    step();
  endtask

  task automatic test_even_miss();
    int rd_cnt = 0;
    ioctl_addr = 25'h10; ioctl_rd = 1'b1;
    step();                                   // cycle 1
    ioctl_rd = 1'b0;
    checks++; if (paddr0 !== 22'h8) begin errors++; $display("FAIL miss_prog_addr got %h want 000008", paddr0); end
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL miss_wait_rise got %b want 1", wait0); end
    for (int i = 1; i <= 3; i++) begin
      if (prd0) rd_cnt++;
      if (i == 3) sdram_ack = 1'b1;
      step();
    end
    sdram_ack = 1'b0;                         // cycle 4
    checks++; if (prd0 !== 1'b0) begin errors++; $display("FAIL miss_prog_rd_drop got %b want 0", prd0); end
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL miss_wait_hold got %b want 1", wait0); end
    data_rdy = 1'b1; data_read = 16'hA55A;
    step();                                   // cycle 5
    data_rdy = 1'b0;
    checks++; if (din0 !== 8'hA5) begin errors++; $display("FAIL miss_din got %h want a5", din0); end
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL miss_wait_fall got %b want 0", wait0); end
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL miss_prog_rd_burst got %0d want 3", rd_cnt); end
  endtask

  task automatic test_odd_hit();
    ioctl_addr = 25'h11; ioctl_rd = 1'b1;
    step();
    checks++; if (din0 !== 8'h5A) begin errors++; $display("FAIL hit_din got %h want 5a", din0); end
    checks++; if (prd0 !== 1'b0 || wait0 !== 1'b0) begin errors++; $display("FAIL hit_quiet got prd=%b wait=%b want 0 0", prd0, wait0); end
    ioctl_addr = 25'h10;                      // back-to-back hits
    step();
    checks++; if (din0 !== 8'hA5) begin errors++; $display("FAIL b2b_hit_even got %h want a5", din0); end
    ioctl_addr = 25'h11;
    step();
    ioctl_rd = 1'b0;
    checks++; if (din0 !== 8'h5A) begin errors++; $display("FAIL b2b_hit_odd got %h want 5a", din0); end
    checks++; if (prd0 !== 1'b0 || wait0 !== 1'b0) begin errors++; $display("FAIL b2b_quiet got prd=%b wait=%b want 0 0", prd0, wait0); end
  endtask

  task automatic test_offset_wrap();
    ioctl_addr = 25'h4; ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    checks++; if (paddr1 !== 22'h1) begin errors++; $display("FAIL offset_prog_addr got %h want 000001", paddr1); end
    checks++; if (paddr0 !== 22'h2) begin errors++; $display("FAIL nooffset_prog_addr got %h want 000002", paddr0); end
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 16'hCAFE;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    checks++; if (din1 !== 8'hCA) begin errors++; $display("FAIL offset_din got %h want ca", din1); end
  endtask

  task automatic test_ack_data_same_cycle();
    ioctl_addr = 25'h21; ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    checks++; if (prd0 !== 1'b1) begin errors++; $display("FAIL simul_req got %b want 1", prd0); end
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 16'h1234;
    step();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    checks++; if (din0 !== 8'h34) begin errors++; $display("FAIL simul_din got %h want 34", din0); end
    checks++; if (wait0 !== 1'b0 || prd0 !== 1'b0) begin errors++; $display("FAIL simul_done got wait=%b prd=%b want 0 0", wait0, prd0); end
    ioctl_addr = 25'h20; ioctl_rd = 1'b1;    // back in IDLE: other byte hits
    step();
    ioctl_rd = 1'b0;
    checks++; if (din0 !== 8'h12) begin errors++; $display("FAIL simul_hit_din got %h want 12", din0); end
    checks++; if (prd0 !== 1'b0 || wait0 !== 1'b0) begin errors++; $display("FAIL simul_hit_quiet got prd=%b wait=%b want 0 0", prd0, wait0); end
  endtask

  task automatic test_timeout();
    ioctl_addr = 25'h40; ioctl_rd = 1'b1;
    step();                                   // cycle 1
    ioctl_rd = 1'b0;
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL to_wait_c1 got %b want 1", wait0); end
    for (int k = 2; k <= 9; k++) begin
      step();
      checks++;
      if (wait0 !== (k < 9)) begin
        errors++; $display("FAIL to_wait_c%0d got %b want %b", k, wait0, (k < 9));
      end
    end
    checks++; if (din0 !== 8'hFF) begin errors++; $display("FAIL to_din got %h want ff", din0); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err0); end
    checks++; if (prd0 !== 1'b0) begin errors++; $display("FAIL to_prog_rd got %b want 0", prd0); end
  endtask

  task automatic test_abort();
    ioctl_addr = 25'h40; ioctl_rd = 1'b1;    // same address misses again
    step();
    ioctl_rd = 1'b0;
    checks++; if (prd0 !== 1'b1 || wait0 !== 1'b1) begin errors++; $display("FAIL remiss got prd=%b wait=%b want 1 1", prd0, wait0); end
    sdram_ack = 1'b1;
    step();                                   // now in WAIT
    sdram_ack = 1'b0;
    uploading = 1'b0; ioctl_rd = 1'b1;
    step();
    checks++; if (prd0 !== 1'b0 || wait0 !== 1'b0) begin errors++; $display("FAIL abort got prd=%b wait=%b want 0 0", prd0, wait0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL abort_err_clear got %b want 0", err0); end
    checks++; if (din0 !== 8'hFF) begin errors++; $display("FAIL abort_din_keep got %h want ff", din0); end
    step();                                   // read while not uploading
    ioctl_rd = 1'b0;
    checks++; if (prd0 !== 1'b0 || wait0 !== 1'b0) begin errors++; $display("FAIL rd_ignored got prd=%b wait=%b want 0 0", prd0, wait0); end
    uploading = 1'b1; data_rdy = 1'b1; data_read = 16'hBEEF;
    step();
    data_rdy = 1'b0;
    checks++; if (din0 !== 8'hFF) begin errors++; $display("FAIL stray_data got %h want ff", din0); end
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL stray_wait got %b want 0", wait0); end
  endtask

  initial begin
    test_reset();
    test_even_miss();
    test_odd_hit();
    test_offset_wrap();
    test_ack_data_same_cycle();
    test_timeout();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
